// File: rtl/dck_loader.sv
// DCK cartridge stream parser: routes each 8 KB chunk to its bank's SDRAM region
// and builds the per-bank chunk presence / writability maps for the memory decoder.
module dck_loader #(
  parameter int                BANKS      = 1,
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] DOCK_BASE  = 23'h040000,
  parameter logic [ADDR_W-1:0] EXROM_BASE = 23'h014000,
  parameter logic [ADDR_W-1:0] HOME_BASE  = 23'h000000
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 dl_active,
  input  logic                 dl_wr,
  input  logic [7:0]           dl_data,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_din,
  output logic                 mem_we,
  output logic [BANKS*8-1:0]   dock_present,
  output logic [BANKS*8-1:0]   dock_ram,
  output logic [7:0]           exrom_present,
  output logic [7:0]           exrom_ram,
  output logic                 done,
  output logic                 err
);

  localparam int MAP_W = BANKS * 8;

  typedef enum logic [1:0] {S_IDLE, S_BANK, S_DESC, S_DATA} state_t;
  typedef enum logic [1:0] {K_DOCK, K_EXROM, K_HOME} kind_t;

  state_t      state;
  kind_t       kind;
  logic        valid;
  logic        act_q;
  logic [2:0]  bank;
  logic [2:0]  idx;
  logic [2:0]  chunk;
  logic [12:0] offset;
  logic [7:0]  data_mask;

  logic             rise;
  logic             fall;
  logic [7:0]       desc_mask;
  logic [3:0]       first_chunk;
  logic [3:0]       next_chunk;
  logic [MAP_W-1:0] hit;

  // Lowest set bit of mask at or above start; result is {found, index}.
  function automatic logic [3:0] find_from(input logic [7:0] mask, input logic [3:0] start);
    logic [3:0] r;
    r = '0;
    for (int c = 7; c >= 0; c--) begin
      if (mask[c] && (4'(c) >= start)) r = {1'b1, 3'(c)};
    end
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] chunk_addr(input kind_t k, input logic [2:0] b,
                                                   input logic [2:0] ch, input logic [12:0] off);
    logic [ADDR_W-1:0] base;
    logic [2:0]        bf;
    case (k)
      K_EXROM: base = EXROM_BASE;
      K_HOME:  base = HOME_BASE;
      default: base = DOCK_BASE;
    endcase
    bf = (k == K_DOCK) ? b : 3'd0;
    return base + ADDR_W'({bf, ch, off});
  endfunction

  always_comb begin
    rise        = dl_active & ~act_q;
    fall        = ~dl_active & act_q;
    desc_mask   = data_mask | (8'(dl_data[0]) << idx);
    first_chunk = find_from(desc_mask, 4'd0);
    next_chunk  = find_from(data_mask, {1'b0, chunk} + 4'd1);
    hit         = '0;
    for (int n = 0; n < BANKS; n++) begin
      for (int c = 0; c < 8; c++) begin
        hit[8*n+c] = (bank == n[2:0]) && (idx == c[2:0]);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      kind          <= K_DOCK;
      valid         <= 1'b0;
      // Held high so a download already in progress at reset release is not seen as a new one.
      act_q         <= 1'b1;
      bank          <= '0;
      idx           <= '0;
      chunk         <= '0;
      offset        <= '0;
      data_mask     <= '0;
      mem_addr      <= '0;
      mem_din       <= '0;
      mem_we        <= 1'b0;
      dock_present  <= '0;
      dock_ram      <= '0;
      exrom_present <= '0;
      exrom_ram     <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      act_q  <= dl_active;
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (fall) begin
        if (state == S_BANK) done <= 1'b1;
        else if (state == S_DESC || state == S_DATA) err <= 1'b1;
        state <= S_IDLE;
      end else if (rise) begin
        dock_present  <= '0;
        dock_ram      <= '0;
        exrom_present <= '0;
        exrom_ram     <= '0;
        err           <= 1'b0;
        state         <= S_BANK;
      end else if (dl_active && dl_wr) begin
        case (state)
          S_BANK: begin
            bank      <= dl_data[2:0];
            idx       <= '0;
            data_mask <= '0;
            state     <= S_DESC;
            if (dl_data == 8'd254) begin
              kind  <= K_EXROM;
              valid <= 1'b1;
            end else if (dl_data == 8'd255) begin
              kind  <= K_HOME;
              valid <= 1'b1;
            end else begin
              kind  <= K_DOCK;
              valid <= (dl_data < 8'(BANKS));
              if (dl_data >= 8'(BANKS)) err <= 1'b1;
            end
          end
          S_DESC: begin
            data_mask <= desc_mask;
            idx       <= idx + 3'd1;
            if (valid && kind == K_DOCK) begin
              dock_present <= dock_present | (hit & {MAP_W{dl_data[0]}});
              dock_ram     <= dock_ram | (hit & {MAP_W{dl_data[1]}});
            end
            if (valid && kind == K_EXROM) begin
              exrom_present[idx] <= exrom_present[idx] | dl_data[0];
              exrom_ram[idx]     <= exrom_ram[idx] | dl_data[1];
            end
            if (idx == 3'd7) begin
              if (first_chunk[3]) begin
                chunk  <= first_chunk[2:0];
                offset <= '0;
                state  <= S_DATA;
              end else begin
                state <= S_BANK;
              end
            end
          end
          S_DATA: begin
            if (valid) begin
              mem_we   <= 1'b1;
              mem_addr <= chunk_addr(kind, bank, chunk, offset);
              mem_din  <= dl_data;
            end
            if (offset == 13'h1FFF) begin
              if (next_chunk[3]) begin
                chunk  <= next_chunk[2:0];
                offset <= '0;
              end else begin
                state <= S_BANK;
              end
            end else begin
              offset <= offset + 13'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dck_loader.sv
// Bench for dck_loader: table of whole-download vectors plus hand-built corner sequences,
// with a write scoreboard fed by the stimulus driver.
module tb_dck_loader;

  localparam int BANKS  = 2;
  localparam int ADDR_W = 23;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              dl_active = 1'b0;
  logic              dl_wr = 1'b0;
  logic [7:0]        dl_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic [BANKS*8-1:0] dock_present;
  logic [BANKS*8-1:0] dock_ram;
  logic [7:0]        exrom_present;
  logic [7:0]        exrom_ram;
  logic              done;
  logic              err;

  dck_loader #(.BANKS(BANKS), .ADDR_W(ADDR_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_data(dl_data), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .dock_present(dock_present), .dock_ram(dock_ram), .exrom_present(exrom_present),
    .exrom_ram(exrom_ram), .done(done), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  id;
    logic [63:0] desc;
    logic [15:0] dp;
    logic [15:0] dr;
    logic [7:0]  ep;
    logic [7:0]  er;
    logic        err;
    int          writes;
  } vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  vec_t vecs[4];
  wr_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   sb_writes = 0;
  int   sb_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk_sys) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      sb_writes++;
      if (exp_q.size() == 0) begin
        sb_err++;
      end else begin
        e = exp_q.pop_front();
        if (e.addr !== mem_addr || e.data !== mem_din) sb_err++;
      end
    end
  end

  function automatic logic [ADDR_W-1:0] model_addr(input logic [7:0] id, input int ch, input int off);
    int base;
    if (id == 8'd254)      base = 'h14000;
    else if (id == 8'd255) base = 0;
    else                   base = 'h40000 + int'(id) * 'h10000;
    return ADDR_W'(base + ch * 8192 + off);
  endfunction

  task automatic put(input logic [7:0] b);
    dl_data = b;
    dl_wr   = 1'b1;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    dl_wr = 1'b0;
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic start_dl();
    dl_wr     = 1'b0;
    dl_active = 1'b1;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic end_dl(input string name, input logic exp_done);
    dl_wr     = 1'b0;
    dl_active = 1'b0;
    @(posedge clk_sys);
    #1;
    check({name, " done"}, done, exp_done);
    @(posedge clk_sys);
    #1;
    check({name, " done_clr"}, done, 1'b0);
  endtask

  // Sends id, descriptors and data; limit >= 0 stops after that many data bytes.
  task automatic send_block(input logic [7:0] id, input logic [63:0] desc, input int limit);
    bit         v;
    int         sent;
    logic [7:0] b;
    v    = (int'(id) < BANKS) || (id >= 8'd254);
    sent = 0;
    put(id);
    for (int c = 0; c < 8; c++) put(desc[8*c +: 8]);
    for (int c = 0; c < 8; c++) begin
      if (desc[8*c]) begin
        for (int off = 0; off < 8192; off++) begin
          if (limit >= 0 && sent >= limit) return;
          b = 8'($urandom);
          if (v) exp_q.push_back({model_addr(id, c, off), b});
          put(b);
          sent++;
        end
      end
    end
  endtask

  task automatic sb_clear();
    sb_writes = 0;
    sb_err    = 0;
    exp_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    vecs[0] = '{8'd0,   64'h0000_0000_0000_0101, 16'h0003, 16'h0000, 8'h00, 8'h00, 1'b0, 16384};
    vecs[1] = '{8'd254, 64'h0000_0000_0000_0003, 16'h0000, 16'h0000, 8'h01, 8'h01, 1'b0, 8192};
    vecs[2] = '{8'd1,   64'h0300_0000_0100_0000, 16'h8800, 16'h8000, 8'h00, 8'h00, 1'b0, 16384};
    vecs[3] = '{8'd255, 64'h0000_0000_0000_0003, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b0, 8192};

    repeat (3) @(posedge clk_sys);
    #1;
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, '0);
    check("rst mem_din", mem_din, '0);
    check("rst dock_present", dock_present, '0);
    check("rst dock_ram", dock_ram, '0);
    check("rst exrom", {exrom_present, exrom_ram}, '0);
    check("rst err_done", {err, done}, '0);
    reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 4; i++) begin
      sb_clear();
      start_dl();
      check($sformatf("v%0d maps_clear", i), {dock_present, dock_ram, exrom_present, exrom_ram}, '0);
      send_block(vecs[i].id, vecs[i].desc, -1);
      end_dl($sformatf("v%0d", i), 1'b1);
      check($sformatf("v%0d dock_present", i), dock_present, vecs[i].dp);
      check($sformatf("v%0d dock_ram", i), dock_ram, vecs[i].dr);
      check($sformatf("v%0d exrom_present", i), exrom_present, vecs[i].ep);
      check($sformatf("v%0d exrom_ram", i), exrom_ram, vecs[i].er);
      check($sformatf("v%0d err", i), err, vecs[i].err);
      check($sformatf("v%0d writes", i), sb_writes, vecs[i].writes);
      check($sformatf("v%0d write_mismatches", i), sb_err, 0);
      check($sformatf("v%0d pending", i), exp_q.size(), 0);
    end

    // Unknown bank id consumed silently, then a valid block in the same download.
    sb_clear();
    start_dl();
    send_block(8'd7, 64'h0000_0000_0000_0001, -1);
    check("unk err", err, 1'b1);
    check("unk no_writes", sb_writes, 0);
    send_block(8'd0, 64'h0000_0000_0003_0000, -1);
    end_dl("unk", 1'b1);
    check("unk dock_present", dock_present, 16'h0004);
    check("unk dock_ram", dock_ram, 16'h0004);
    check("unk err_sticky", err, 1'b1);
    check("unk writes", sb_writes, 8192);
    check("unk write_mismatches", sb_err, 0);

    // Truncated download, with map update latency checked on the first descriptor.
    sb_clear();
    start_dl();
    check("trunc err_cleared", err, 1'b0);
    put(8'd0);
    put(8'h01);
    check("trunc map_latency", dock_present[0], 1'b1);
    for (int c = 1; c < 8; c++) put(8'h00);
    for (int off = 0; off < 100; off++) begin
      b = 8'($urandom);
      exp_q.push_back({model_addr(8'd0, 0, off), b});
      put(b);
    end
    end_dl("trunc", 1'b0);
    check("trunc err", err, 1'b1);
    check("trunc writes", sb_writes, 100);
    check("trunc write_mismatches", sb_err, 0);
    start_dl();
    check("trunc restart err", err, 1'b0);
    check("trunc restart maps", dock_present, '0);
    end_dl("empty", 1'b1);

    // Reset in the middle of a chunk.
    sb_clear();
    start_dl();
    put(8'd0);
    put(8'h01);
    for (int c = 1; c < 8; c++) put(8'h00);
    for (int off = 0; off < 50; off++) begin
      b = 8'($urandom);
      exp_q.push_back({model_addr(8'd0, 0, off), b});
      put(b);
    end
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) put(8'($urandom));
    check("midrst mem_we", mem_we, 1'b0);
    check("midrst mem_addr", mem_addr, '0);
    check("midrst mem_din", mem_din, '0);
    check("midrst maps", {dock_present, dock_ram}, '0);
    check("midrst err", err, 1'b0);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) put(8'($urandom));
    idle(2);
    check("midrst writes", sb_writes, 50);
    check("midrst write_mismatches", sb_err, 0);
    check("midrst pending", exp_q.size(), 0);
    end_dl("midrst", 1'b0);
    check("midrst err_after", err, 1'b0);
    start_dl();
    send_block(8'd255, 64'h0, -1);
    end_dl("fresh", 1'b1);
    check("fresh err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dck_loader.md
# dck_loader

Parametrised DCK cartridge loader for the TS2068 core. It replaces the flat "DOCK file written linearly at 0x40000 plus a block counter" scheme. It parses the DCK block stream coming from the data_io download port and writes each 8 KB chunk to its own SDRAM region. It also builds per-bank chunk-presence and writability maps, which the memory decoder uses in place of `dock_blocks`. It sits between data_io and the SDRAM write mux, on the `clk_sys` domain.

## Interface
Parameters:
- `BANKS`, 1: number of DOCK-type banks accepted (bank ids 0..BANKS-1), 1..8.
- `ADDR_W`, 23: SDRAM byte-address width.
- `DOCK_BASE`, 23'h040000: base address of bank 0. Bank n sits at DOCK_BASE + n*64K.
- `EXROM_BASE`, 23'h014000: base address of the EXROM region (bank id 254), 64 KB span.
- `HOME_BASE`, 23'h000000: base address of the HOME region (bank id 255), 64 KB span.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `dl_active` in 1: DCK download in progress (`ioctl_download` gated with index 1).
- `dl_wr` in 1: one-cycle strobe, byte valid on `dl_data`.
- `dl_data` in 8: download byte.
- `mem_addr` out ADDR_W: SDRAM write address.
- `mem_din` out 8: SDRAM write data.
- `mem_we` out 1: one-cycle write strobe.
- `dock_present` out BANKS*8: bit [8n+c] means bank n chunk c was loaded.
- `dock_ram` out BANKS*8: bit [8n+c] means bank n chunk c is writable.
- `exrom_present` out 8: presence map for bank 254.
- `exrom_ram` out 8: writable map for bank 254.
- `done` out 1: one-cycle pulse on a clean end of download.
- `err` out 1: sticky; unknown bank id or truncated stream.

## Operation
- Stream format: repeated blocks, each made of a bank-id byte, then 8 descriptor bytes (chunk 0..7), then 8192 data bytes for every chunk whose descriptor bit0 = 1, in ascending chunk order.
- Descriptor bits: bit0 = data follows; bit1 = RAM (writable). Bits 7:2 are ignored.
- A rising edge of `dl_active` clears all maps, `err`, and the state. Bytes arriving while `dl_active` = 0 are ignored.
- State machine:
  - IDLE: on `dl_active` rise, go to BANK.
  - BANK: on `dl_wr`, latch the id. Set `valid` if id < BANKS, id = 254, or id = 255; otherwise set `err` and clear `valid`. Clear the descriptor index, then go to DESC.
  - DESC: on each `dl_wr`, store the descriptor byte in an 8-entry holding register. If `valid` and the target is not HOME, write bit0 into the present map at [bank][idx] and bit1 into the RAM map at [bank][idx]. On the 8th byte, select the lowest chunk with bit0 = 1: if one exists go to DATA with offset 0, otherwise go to BANK.
  - DATA: on each `dl_wr`, if `valid`, drive `mem_addr` = base + chunk*8192 + offset, `mem_din` = byte, and pulse `mem_we`. If not `valid`, consume the byte with no write. At offset 8191, advance to the next higher chunk with bit0 = 1; if none remains, go to BANK.
  - Any state: `dl_active` fall. From BANK, pulse `done` and go to IDLE. From DESC or DATA, set `err`, go to IDLE, no `done`.
- HOME blocks write data but do not update any map. Their descriptor bit1 is ignored.
- Duplicate bank ids: a later block ORs its bits into the maps and overwrites the data.
- Arithmetic: the chunk field is 3 bits and the offset 13 bits. Address = base + {bank[2:0] for DOCK else 0, chunk, offset}, zero-extended to ADDR_W, no wrap checking.

## Timing
- Reset: state IDLE; all maps, `err`, `done`, `mem_we` = 0; `mem_addr`, `mem_din` = 0.
- Write latency: `mem_we` is high exactly one cycle, the cycle after the `dl_wr` cycle. `mem_addr` and `mem_din` are registered with it and hold until the next write.
- Back-to-back `dl_wr` on consecutive cycles must be accepted with no lost bytes.
- Map bits update in the cycle after their descriptor `dl_wr`.
- `done` is asserted the cycle after `dl_active` is sampled low.
- If `dl_wr` and the `dl_active` fall occur in the same cycle, the byte is ignored and the fall is processed.
- A `reset_n` low mid-stream aborts with no further writes. The next `dl_active` rise starts a fresh parse.

## Test plan
- DOCK block: id 0, descriptors {01,01,00×6}, then 16384 bytes -> writes to 0x040000–0x043FFF in order. `dock_present[7:0]` = 0x03, `dock_ram` = 0, `done` pulses once.
- EXROM block: id 254, descriptors {03,00×7}, then 8192 bytes -> writes to 0x014000–0x015FFF. `exrom_present` = 0x01, `exrom_ram` = 0x01.
- Sparse chunks with BANKS=2: id 1, descriptors {00,00,00,01,00,00,00,03} -> first write at 0x056000, then 0x05E000 after 8192 bytes. `dock_present[15:8]` = 0x88, `dock_ram[15:8]` = 0x80.
- Unknown id 7 with BANKS=1, one data chunk, followed by a valid id-0 block -> no `mem_we` during the first block, `err` = 1, second block loads normally.
- Truncation: `dl_active` drops after 100 data bytes -> exactly 100 writes, `err` = 1, no `done`. A new download clears `err` and the maps.
- Throughput and reset: `dl_wr` on every cycle for a full chunk gives 8192 `mem_we` pulses. `reset_n` low mid-chunk gives zero outputs and no further writes.
